constraint_stream_checker: RTL and testbench

- Streaming, parametrised successor to the generated single-shot constraint checkers.
- Accepts candidate samples as packed per-constraint term vectors over a valid/ready handshake. Each term is OR-reduced to a constraint bit in a 2-stage pipeline.
- Emits a verdict per sample: sat flag, violation mask and first-violated index. Also keeps sample and accept statistics.
- Runs a sampling session that stops once a target number of satisfying samples has been produced.
- Sits between the generated constraint-term logic and the sampler's result collector.

---
 rtl/constraint_stream_checker_pkg.sv | 21 ++
 rtl/constraint_stream_checker_verdict.sv | 36 +++
 rtl/constraint_stream_checker.sv | 164 ++++++++++++++++
 tb/tb_constraint_stream_checker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/constraint_stream_checker_pkg.sv
// Shared types and defaults for the streaming constraint checker family.
package constraint_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NUM_CONS_DEF = 35;
  localparam int TERM_W_DEF   = 16;
  localparam int TAG_W_DEF    = 8;
  localparam int CNT_W_DEF    = 32;

  // Wide enough to hold any index 0..n-1 and also the count n itself.
  function automatic int idx_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/constraint_stream_checker_verdict.sv
// Combinational verdict: popcount against a minimum, violation mask and lowest violated index.
module cons_verdict #(
  parameter int NUM_CONS = 35,
  parameter int IDX_W    = 6
) (
  input  logic [NUM_CONS-1:0] i_cbit,
  input  logic [IDX_W-1:0]    i_eff_min,
  output logic                o_sat,
  output logic [NUM_CONS-1:0] o_viol_mask,
  output logic [IDX_W-1:0]    o_first_viol,
  output logic                o_first_viol_vld
);

  logic [IDX_W-1:0] w_sat_count;
  logic [IDX_W-1:0] w_first;
  logic             w_found;

  always_comb begin
    w_sat_count = '0;
    w_first     = '0;
    w_found     = 1'b0;
    for (int k = 0; k < NUM_CONS; k++) begin
      w_sat_count = w_sat_count + IDX_W'(i_cbit[k]);
      if (!i_cbit[k] && !w_found) begin
        w_first = IDX_W'(k);
        w_found = 1'b1;
      end
    end
  end

  assign o_sat            = (w_sat_count >= i_eff_min);
  assign o_viol_mask      = ~i_cbit;
  assign o_first_viol     = w_first;
  assign o_first_viol_vld = w_found;

endmodule

// File: rtl/constraint_stream_checker.sv
// Two-stage constraint checker: OR-reduce terms (S1), verdict (S2); 2-cycle latency, 1 sample/cycle.
// S2 holds under out_ready=0, S1 only advances into a free or draining S2; session ends after target sat verdicts.
module constraint_stream_checker
  import constraint_pkg::*;
#(
  parameter int NUM_CONS = NUM_CONS_DEF,
  parameter int TERM_W   = TERM_W_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int IDX_W    = idx_width(NUM_CONS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNT_W-1:0]           target_cnt,
  input  logic [IDX_W-1:0]           min_sat,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CONS*TERM_W-1:0] in_terms,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_sat,
  output logic [NUM_CONS-1:0]        out_viol_mask,
  output logic [IDX_W-1:0]           out_first_viol,
  output logic                       out_first_viol_vld,
  output logic [CNT_W-1:0]           sample_cnt,
  output logic [CNT_W-1:0]           accept_cnt,
  output logic                       busy,
  output logic                       done
);

  localparam logic [IDX_W-1:0] L_NUM_CONS = IDX_W'(NUM_CONS);

  state_t                r_state, w_state_next;
  logic [CNT_W-1:0]      r_target, r_sample_cnt, r_accept_cnt;
  logic [IDX_W-1:0]      r_eff_min;
  logic                  r_busy, r_done;

  logic                  r_s1_vld;
  logic [TAG_W-1:0]      r_s1_tag;
  logic [NUM_CONS-1:0]   r_s1_cbit;

  logic                  r_s2_vld;
  logic [TAG_W-1:0]      r_s2_tag;
  logic                  r_s2_sat;
  logic [NUM_CONS-1:0]   r_s2_mask;
  logic [IDX_W-1:0]      r_s2_first;
  logic                  r_s2_fvld;

  logic [NUM_CONS-1:0]   w_cbit;
  logic                  w_sat, w_fvld;
  logic [NUM_CONS-1:0]   w_mask;
  logic [IDX_W-1:0]      w_first;
  logic [IDX_W-1:0]      w_eff_min_in;
  logic [CNT_W:0]        w_acc_inc;
  logic                  w_s2_fire, w_s1_adv, w_in_fire, w_target_hit, w_start_ok, w_in_ready;

  always_comb begin
    w_cbit = '0;
    for (int k = 0; k < NUM_CONS; k++) w_cbit[k] = |in_terms[k*TERM_W +: TERM_W];
  end

  cons_verdict #(.NUM_CONS(NUM_CONS), .IDX_W(IDX_W)) u_verdict (
    .i_cbit           (r_s1_cbit),
    .i_eff_min        (r_eff_min),
    .o_sat            (w_sat),
    .o_viol_mask      (w_mask),
    .o_first_viol     (w_first),
    .o_first_viol_vld (w_fvld)
  );

  assign w_eff_min_in = (min_sat >= L_NUM_CONS) ? L_NUM_CONS : min_sat;
  assign w_start_ok   = start && (r_state == IDLE || r_state == DONE);
  assign w_s2_fire    = r_s2_vld && out_ready;
  assign w_s1_adv     = r_s1_vld && (!r_s2_vld || out_ready);
  // Widened by one bit so the compare never wraps at the saturation point.
  assign w_acc_inc    = {1'b0, r_accept_cnt} + (CNT_W+1)'(1);
  assign w_target_hit = (r_state == RUN) && w_s2_fire && r_s2_sat && (w_acc_inc >= {1'b0, r_target});
  assign w_in_ready   = (r_state == RUN) && (!r_s1_vld || w_s1_adv) && !w_target_hit;
  assign w_in_fire    = in_valid && w_in_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_next = (target_cnt == '0) ? DONE : RUN;
      RUN:        if (w_target_hit) w_state_next = DRAIN;
      DRAIN:      if (!r_s1_vld && !r_s2_vld) w_state_next = DONE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_target     <= '0;
      r_eff_min    <= '0;
      r_sample_cnt <= '0;
      r_accept_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == RUN) || (w_state_next == DRAIN);
      r_done  <= (w_state_next == DONE);
      if (w_start_ok) begin
        r_target     <= target_cnt;
        r_eff_min    <= w_eff_min_in;
        r_sample_cnt <= '0;
        r_accept_cnt <= '0;
      end else if (w_s2_fire) begin
        if (r_sample_cnt != '1) r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        if (r_s2_sat && r_accept_cnt != '1) r_accept_cnt <= r_accept_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_cbit  <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_tag   <= '0;
      r_s2_sat   <= 1'b0;
      r_s2_mask  <= '0;
      r_s2_first <= '0;
      r_s2_fvld  <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_vld  <= 1'b1;
        r_s1_tag  <= in_tag;
        r_s1_cbit <= w_cbit;
      end else if (w_s1_adv) begin
        r_s1_vld <= 1'b0;
      end
      // Verdict fields load only on advance, so they stay frozen while stalled.
      if (w_s1_adv) begin
        r_s2_vld   <= 1'b1;
        r_s2_tag   <= r_s1_tag;
        r_s2_sat   <= w_sat;
        r_s2_mask  <= w_mask;
        r_s2_first <= w_first;
        r_s2_fvld  <= w_fvld;
      end else if (w_s2_fire) begin
        r_s2_vld <= 1'b0;
      end
    end
  end

  assign in_ready           = w_in_ready;
  assign out_valid          = r_s2_vld;
  assign out_tag            = r_s2_tag;
  assign out_sat            = r_s2_sat;
  assign out_viol_mask      = r_s2_mask;
  assign out_first_viol     = r_s2_first;
  assign out_first_viol_vld = r_s2_fvld;
  assign sample_cnt         = r_sample_cnt;
  assign accept_cnt         = r_accept_cnt;
  assign busy               = r_busy;
  assign done               = r_done;

endmodule

// File: tb/tb_constraint_stream_checker.sv
// Directed bench: table of single-sample verdicts plus hand-written streaming, stall, target-0 and reset sequences.
module tb_constraint_stream_checker;

  localparam int NC = 35;
  localparam int TW = 16;
  localparam int GW = 8;
  localparam int CW = 32;
  localparam int IW = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CW-1:0]     target_cnt = '0;
  logic [IW-1:0]     min_sat = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NC*TW-1:0]  in_terms = '0;
  logic [GW-1:0]     in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [GW-1:0]     out_tag;
  logic              out_sat;
  logic [NC-1:0]     out_viol_mask;
  logic [IW-1:0]     out_first_viol;
  logic              out_first_viol_vld;
  logic [CW-1:0]     sample_cnt;
  logic [CW-1:0]     accept_cnt;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;
  int first_in, first_out;

  always #5 clk = ~clk;

  constraint_stream_checker #(.NUM_CONS(NC), .TERM_W(TW), .TAG_W(GW), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .target_cnt(target_cnt), .min_sat(min_sat),
    .in_valid(in_valid), .in_ready(in_ready), .in_terms(in_terms), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_sat(out_sat),
    .out_viol_mask(out_viol_mask), .out_first_viol(out_first_viol),
    .out_first_viol_vld(out_first_viol_vld), .sample_cnt(sample_cnt), .accept_cnt(accept_cnt),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [NC-1:0] nz;
    logic [TW-1:0] pat;
    logic [IW-1:0] min;
    logic          exp_sat;
    logic [NC-1:0] exp_mask;
    logic [IW-1:0] exp_first;
    logic          exp_fvld;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_start(input logic [CW-1:0] t, input logic [IW-1:0] m);
    start = 1'b1; target_cnt = t; min_sat = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic set_terms(input logic [NC-1:0] nz, input logic [TW-1:0] pat);
    logic [2*TW-1:0] d;
    for (int k = 0; k < NC; k++) begin
      d = {pat, pat} << (k % TW);
      in_terms[k*TW +: TW] = nz[k] ? d[2*TW-1:TW] : '0;
    end
  endtask

  task automatic run_stream(input int target, input int n_send, input int hold,
                            input int base, input int exp_out);
    int n_in, n_out;
    logic prev_stall, ended;
    logic [GW-1:0] s_tag;
    logic [NC-1:0] s_mask;
    logic [IW-1:0] s_first;
    n_in = 0; n_out = 0; prev_stall = 1'b0; ended = 1'b0;
    s_tag = '0; s_mask = '0; s_first = '0;
    first_in = -1; first_out = -1;
    for (int c = 0; c < 80 && !ended; c++) begin
      in_valid  = (n_in < n_send);
      in_tag    = GW'(base + n_in);
      out_ready = (c >= hold);
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_vld", out_valid, 1);
        chk("stall_tag", out_tag, s_tag);
        chk("stall_mask", out_viol_mask, s_mask);
        chk("stall_first", out_first_viol, s_first);
      end
      prev_stall = out_valid && !out_ready;
      s_tag = out_tag; s_mask = out_viol_mask; s_first = out_first_viol;
      if (c >= 2 && c < hold) chk("stall_in_ready", in_ready, 0);
      if (in_valid && in_ready) begin
        if (first_in < 0) first_in = c;
        n_in++;
      end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = c;
        chk("stream_tag", out_tag, GW'(base + n_out));
        chk("stream_sat", out_sat, 1);
        n_out++;
        if (n_out == target) begin
          chk("target_in_ready", in_ready, 0);
          chk("target_busy", busy, 1);
        end
      end
      if (hold > 0 && c == hold - 1) chk("stall_accepts", n_in, 2);
      @(posedge clk); #1;
      ended = done || (n_out >= n_send);
    end
    in_valid = 1'b0;
    chk("stream_ended", ended, 1);
    chk("stream_count", n_out, exp_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic got;
    //           nz               pat      min    sat   mask             first  fvld
    vecs[0] = '{35'h7_FFFF_FFFF, 16'h0001, 6'd35, 1'b1, 35'h0_0000_0000, 6'd0,  1'b0};
    vecs[1] = '{35'h7_FFFD_FFEF, 16'h8000, 6'd35, 1'b0, 35'h0_0002_0010, 6'd4,  1'b1};
    vecs[2] = '{35'h7_FFFD_FFEF, 16'h8000, 6'd33, 1'b1, 35'h0_0002_0010, 6'd4,  1'b1};
    vecs[3] = '{35'h7_FFFD_FFEF, 16'hFFFF, 6'd34, 1'b0, 35'h0_0002_0010, 6'd4,  1'b1};
    vecs[4] = '{35'h0_0000_0000, 16'h0001, 6'd0,  1'b1, 35'h7_FFFF_FFFF, 6'd0,  1'b1};
    vecs[5] = '{35'h3_FFFF_FFFF, 16'h0100, 6'd63, 1'b0, 35'h4_0000_0000, 6'd34, 1'b1};
    vecs[6] = '{35'h7_FFFF_FFFE, 16'h0001, 6'd34, 1'b1, 35'h0_0000_0001, 6'd0,  1'b1};
    vecs[7] = '{35'h7_FFFF_FFFF, 16'h0010, 6'd63, 1'b1, 35'h0_0000_0000, 6'd0,  1'b0};
    vecs[8] = '{35'h0_0010_0000, 16'h0002, 6'd1,  1'b1, 35'h7_FFEF_FFFF, 6'd0,  1'b1};

    // Reset state
    do_reset();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mask", out_viol_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_accept_cnt", accept_cnt, 0);

    // Single-sample verdict table
    for (int i = 0; i < 9; i++) begin
      do_reset();
      do_start(100, vecs[i].min);
      set_terms(vecs[i].nz, vecs[i].pat);
      in_tag = GW'(i + 8'h40); in_valid = 1'b1; out_ready = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        @(negedge clk); got = in_ready;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("vec_in_hs", got, 1);
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        @(negedge clk); got = out_valid;
        if (!got) begin @(posedge clk); #1; end
      end
      chk("vec_out_valid", got, 1);
      chk("vec_tag", out_tag, GW'(i + 8'h40));
      chk("vec_sat", out_sat, vecs[i].exp_sat);
      chk("vec_mask", out_viol_mask, vecs[i].exp_mask);
      chk("vec_first", out_first_viol, vecs[i].exp_first);
      chk("vec_fvld", out_first_viol_vld, vecs[i].exp_fvld);
      @(posedge clk); #1;
      chk("vec_sample_cnt", sample_cnt, 1);
      chk("vec_accept_cnt", accept_cnt, {31'b0, vecs[i].exp_sat});
    end

    // Target 3, continuous stream: one extra sample in flight completes
    do_reset();
    set_terms(35'h7_FFFF_FFFF, 16'h0001);
    do_start(3, 6'd35);
    chk("run_busy", busy, 1);
    run_stream(3, 100, 0, 0, 4);
    chk("run_latency", first_out - first_in, 2);
    chk("run_accept_cnt", accept_cnt, 4);
    chk("run_sample_cnt", sample_cnt, 4);
    chk("run_done", done, 1);
    chk("run_busy_end", busy, 0);
    chk("run_out_valid_end", out_valid, 0);

    // Output stall of 5 cycles with input pressure
    do_reset();
    do_start(100, 6'd35);
    run_stream(100, 6, 5, 8'h20, 6);
    chk("stall_sample_cnt", sample_cnt, 6);
    chk("stall_accept_cnt", accept_cnt, 6);

    // Target zero: straight to DONE, never ready
    do_reset();
    do_start(0, 6'd35);
    chk("t0_done", done, 1);
    chk("t0_busy", busy, 0);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t0_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    do_start(1, 6'd35);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    run_stream(1, 100, 0, 8'h10, 2);
    chk("restart_accept_cnt", accept_cnt, 2);

    // Reset mid-session with two samples in flight
    do_reset();
    do_start(100, 6'd35);
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 8'hA0;
    @(posedge clk); #1;
    in_tag = 8'hA1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_out_valid_before", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_in_ready", in_ready, 0);
    chk("mid_sample_cnt", sample_cnt, 0);
    chk("mid_accept_cnt", accept_cnt, 0);
    do_start(2, 6'd35);
    run_stream(2, 100, 0, 0, 3);
    chk("mid_restart_sample_cnt", sample_cnt, 3);
    chk("mid_restart_accept_cnt", accept_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
